// File: rtl/int_divider_seq.sv
// Sequential restoring integer divider: one quotient bit per cycle, valid strobe, defined divide-by-zero.
// Define INT_DIVIDER_SIGNED_EN to add two's-complement division when sgn=1.
module int_divider_seq #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sgn,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             err
);

    typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] dvd_sh;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] part;
    logic [WIDTH-1:0] q_sh;
    logic [WIDTH-1:0] dvd_in;
    logic [WIDTH-1:0] dvs_in;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;
    logic [WIDTH:0]   part_sh;
    logic [WIDTH-1:0] part_nxt;
    logic             fit;

    assign ready = (state == IDLE);
    assign valid = (state == DONE);

`ifdef INT_DIVIDER_SIGNED_EN
    logic neg_q, neg_r, dvd_neg, dvs_neg;

    assign dvd_neg = sgn & dividend[WIDTH-1];
    assign dvs_neg = sgn & divisor[WIDTH-1];
    assign dvd_in  = dvd_neg ? -dividend : dividend;
    assign dvs_in  = dvs_neg ? -divisor : divisor;

    // Result signs are captured with the operands; magnitudes go through the unsigned core.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (ready && start) begin
            neg_q <= dvd_neg ^ dvs_neg;
            neg_r <= dvd_neg;
        end
    end

    assign q_fix = neg_q ? -q_sh : q_sh;
    assign r_fix = neg_r ? -part : part;
`else
    logic unused_sgn;

    assign unused_sgn = sgn;
    assign dvd_in     = dividend;
    assign dvs_in     = divisor;
    assign q_fix      = q_sh;
    assign r_fix      = part;
`endif

    // The shifted partial remainder needs one extra bit; after a subtraction it always fits WIDTH bits.
    always_comb begin
        part_sh  = {part, dvd_sh[WIDTH-1]};
        fit      = (part_sh >= {1'b0, dvs_mag});
        part_nxt = fit ? (part_sh[WIDTH-1:0] - dvs_mag) : part_sh[WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (divisor == '0) ? DONE : DIV;
            DIV:     if (cnt == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Counter reaching zero marks the extra fix-up cycle in which results are published.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            dvd_sh    <= '0;
            dvs_mag   <= '0;
            part      <= '0;
            q_sh      <= '0;
            quotient  <= '0;
            remainder <= '0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            quotient  <= '1;
                            remainder <= dividend;
                            err       <= 1'b1;
                        end else begin
                            err     <= 1'b0;
                            dvd_sh  <= dvd_in;
                            dvs_mag <= dvs_in;
                            part    <= '0;
                            q_sh    <= '0;
                            cnt     <= CNT_W'(WIDTH);
                        end
                    end
                end
                DIV: begin
                    if (cnt != '0) begin
                        dvd_sh <= dvd_sh << 1;
                        part   <= part_nxt;
                        q_sh   <= {q_sh[WIDTH-2:0], fit};
                        cnt    <= cnt - 1'b1;
                    end else begin
                        quotient  <= q_fix;
                        remainder <= r_fix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_int_divider_seq.sv
// Self-checking bench for int_divider_seq at WIDTH=8 and WIDTH=13 against an arithmetic reference model.
`timescale 1ns/1ps
module tb_int_divider_seq;

`ifdef INT_DIVIDER_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    logic        start8, sgn8, ready8, valid8, err8;
    logic [7:0]  dvd8, dvs8, q8, r8;
    logic        start13, sgn13, ready13, valid13, err13;
    logic [12:0] dvd13, dvs13, q13, r13;

    int n_cmp  = 0;
    int n_fail = 0;
    int acc8 = 0, val8 = 0, acc13 = 0, val13 = 0;

    always #5 clk = ~clk;

    int_divider_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .sgn(sgn8), .dividend(dvd8), .divisor(dvs8),
        .ready(ready8), .valid(valid8), .quotient(q8), .remainder(r8), .err(err8)
    );

    int_divider_seq #(.WIDTH(13)) dut13 (
        .clk(clk), .rst(rst), .start(start13), .sgn(sgn13), .dividend(dvd13), .divisor(dvs13),
        .ready(ready13), .valid(valid13), .quotient(q13), .remainder(r13), .err(err13)
    );

    // Accepted starts and valid pulses, seen as the DUT sees them at the edge.
    always @(posedge clk) begin
        if (!rst) begin
            if (start8 && ready8)   acc8++;
            if (valid8)             val8++;
            if (start13 && ready13) acc13++;
            if (valid13)            val13++;
        end
    end

    // Reference: plain integer division, signed values reconstructed from the WIDTH-bit patterns.
    function automatic void ref_div(input int w, input logic s, input logic [63:0] a, input logic [63:0] b,
                                    output logic [63:0] q, output logic [63:0] r, output logic e);
        logic [63:0] mask;
        longint      sa, sb;
        mask = (64'd1 << w) - 64'd1;
        if (b == 64'd0) begin
            q = mask;
            r = a;
            e = 1'b1;
            return;
        end
        e = 1'b0;
        if (SIGNED_EN && s) begin
            sa = longint'(a);
            sb = longint'(b);
            if (a[w-1]) sa = sa - longint'(64'd1 << w);
            if (b[w-1]) sb = sb - longint'(64'd1 << w);
            q = 64'(sa / sb) & mask;
            r = 64'(sa % sb) & mask;
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    task automatic drive(input int w, input logic st, input logic s, input logic [63:0] a, input logic [63:0] b);
        if (w == 8) begin
            start8 = st; sgn8 = s; dvd8 = a[7:0]; dvs8 = b[7:0];
        end else begin
            start13 = st; sgn13 = s; dvd13 = a[12:0]; dvs13 = b[12:0];
        end
    endtask

    task automatic set_start(input int w, input logic st);
        if (w == 8) start8 = st;
        else        start13 = st;
    endtask

    // Issues one division; lat = edges after the sampling edge until valid, low = cycles with ready low.
    task automatic run_op(input int w, input logic s, input logic [63:0] a, input logic [63:0] b, input bit noise,
                          output logic [63:0] q, output logic [63:0] r, output logic e,
                          output int lat, output int low);
        logic rdy, vld;
        int   guard;
        q = '0; r = '0; e = 1'b0;
        guard = 0;
        while (!((w == 8) ? ready8 : ready13) && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        drive(w, 1'b1, s, a, b);
        @(posedge clk); #1;
        drive(w, 1'b0, ~s, {$urandom, $urandom}, {$urandom, $urandom});
        lat = -1;
        low = 0;
        for (int n = 0; n < 64; n++) begin
            rdy = (w == 8) ? ready8 : ready13;
            vld = (w == 8) ? valid8 : valid13;
            if (!rdy) low++;
            if (vld && lat < 0) begin
                lat = n;
                q = (w == 8) ? 64'(q8) : 64'(q13);
                r = (w == 8) ? 64'(r8) : 64'(r13);
                e = (w == 8) ? err8 : err13;
            end
            if (rdy) break;
            if (noise) set_start(w, 1'($urandom_range(0, 1)));
            @(posedge clk); #1;
        end
        set_start(w, 1'b0);
    endtask

    task automatic test_reset();
        drive(8, 1'b0, 1'b0, 64'd0, 64'd0);
        drive(13, 1'b0, 1'b0, 64'd0, 64'd0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({ready8, valid8, err8, q8, r8} !== {1'b1, 1'b0, 1'b0, 8'd0, 8'd0}) begin
            n_fail++;
            $display("[TB] FAIL reset_w8: got rdy=%b vld=%b err=%b q=%0h r=%0h, expected 1 0 0 0 0", ready8, valid8, err8, q8, r8);
        end
        n_cmp++;
        if ({ready13, valid13, err13, q13, r13} !== {1'b1, 1'b0, 1'b0, 13'd0, 13'd0}) begin
            n_fail++;
            $display("[TB] FAIL reset_w13: got rdy=%b vld=%b err=%b q=%0h r=%0h, expected 1 0 0 0 0", ready13, valid13, err13, q13, r13);
        end
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [63:0] q, r; logic e; int lat, low;
        run_op(8, 1'b0, 64'd100, 64'd7, 1'b0, q, r, e, lat, low);
        n_cmp++;
        if ({q, r, e} !== {64'd14, 64'd2, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL basic_100_7: got q=%0d r=%0d err=%b, expected q=14 r=2 err=0", q, r, e);
        end
        n_cmp++;
        if (lat !== 9 || low !== 10) begin
            n_fail++;
            $display("[TB] FAIL basic_timing: got latency=%0d ready_low=%0d, expected 9 and 10", lat, low);
        end
    endtask

    task automatic test_div_zero();
        logic [63:0] q, r; logic e; int lat, low;
        run_op(8, 1'b0, 64'd200, 64'd0, 1'b0, q, r, e, lat, low);
        n_cmp++;
        if ({q, r, e} !== {64'hFF, 64'd200, 1'b1}) begin
            n_fail++;
            $display("[TB] FAIL divzero_result: got q=%0h r=%0d err=%b, expected q=ff r=200 err=1", q, r, e);
        end
        n_cmp++;
        if (lat !== 0 || low !== 1) begin
            n_fail++;
            $display("[TB] FAIL divzero_timing: got latency=%0d ready_low=%0d, expected 0 and 1", lat, low);
        end
        run_op(8, 1'b0, 64'd9, 64'd3, 1'b0, q, r, e, lat, low);
        n_cmp++;
        if ({q, r, e, lat} !== {64'd3, 64'd0, 1'b0, 32'sd9}) begin
            n_fail++;
            $display("[TB] FAIL after_divzero: got q=%0d r=%0d err=%b lat=%0d, expected 3 0 0 9", q, r, e, lat);
        end
    endtask

    task automatic test_back_to_back();
        int a0, v0, guard;
        logic [7:0] q1, r1, q2, r2;
        a0 = acc8;
        v0 = val8;
        start8 = 1'b1; sgn8 = 1'b0; dvd8 = 8'd255; dvs8 = 8'd1;
        @(posedge clk); #1;
        dvd8 = 8'd0; dvs8 = 8'd5;
        guard = 0;
        while (!valid8 && guard < 40) begin @(posedge clk); #1; guard++; end
        q1 = q8; r1 = r8;
        guard = 0;
        while (!ready8 && guard < 40) begin @(posedge clk); #1; guard++; end
        @(posedge clk); #1;
        start8 = 1'b0;
        guard = 0;
        while (!valid8 && guard < 40) begin @(posedge clk); #1; guard++; end
        q2 = q8; r2 = r8;
        guard = 0;
        while (!ready8 && guard < 40) begin @(posedge clk); #1; guard++; end
        n_cmp++;
        if ({q1, r1} !== {8'd255, 8'd0}) begin
            n_fail++;
            $display("[TB] FAIL b2b_first: got q=%0d r=%0d, expected q=255 r=0", q1, r1);
        end
        n_cmp++;
        if ({q2, r2} !== {8'd0, 8'd0}) begin
            n_fail++;
            $display("[TB] FAIL b2b_second: got q=%0d r=%0d, expected q=0 r=0", q2, r2);
        end
        n_cmp++;
        if (acc8 - a0 !== 2 || val8 - v0 !== 2) begin
            n_fail++;
            $display("[TB] FAIL b2b_counts: got accepted=%0d valids=%0d, expected 2 and 2", acc8 - a0, val8 - v0);
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] q, r; logic e; int lat, low, v0;
        run_op(8, 1'b0, 64'd77, 64'd4, 1'b0, q, r, e, lat, low);
        drive(8, 1'b1, 1'b0, 64'd77, 64'd4);
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({ready8, valid8, err8, q8, r8} !== {1'b1, 1'b0, 1'b0, 8'd0, 8'd0}) begin
            n_fail++;
            $display("[TB] FAIL midreset_async: got rdy=%b vld=%b err=%b q=%0d r=%0d, expected 1 0 0 0 0", ready8, valid8, err8, q8, r8);
        end
        v0 = val8;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        n_cmp++;
        if (val8 !== v0 || ready8 !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL midreset_no_valid: got valids=%0d ready=%b, expected %0d and 1", val8, ready8, v0);
        end
        run_op(8, 1'b0, 64'd77, 64'd4, 1'b0, q, r, e, lat, low);
        n_cmp++;
        if ({q, r, e, lat} !== {64'd19, 64'd1, 1'b0, 32'sd9}) begin
            n_fail++;
            $display("[TB] FAIL midreset_rerun: got q=%0d r=%0d err=%b lat=%0d, expected 19 1 0 9", q, r, e, lat);
        end
    endtask

    task automatic test_signed();
        logic [63:0] q, r; logic e; int lat, low;
`ifdef INT_DIVIDER_SIGNED_EN
        run_op(8, 1'b1, 64'hF9, 64'd2, 1'b0, q, r, e, lat, low);
        n_cmp++;
        if ({q, r, e, lat} !== {64'hFD, 64'hFF, 1'b0, 32'sd9}) begin
            n_fail++;
            $display("[TB] FAIL signed_m7_2: got q=%0h r=%0h err=%b lat=%0d, expected fd ff 0 9", q, r, e, lat);
        end
        run_op(8, 1'b1, 64'd7, 64'hFE, 1'b0, q, r, e, lat, low);
        n_cmp++;
        if ({q, r, e, lat} !== {64'hFD, 64'h01, 1'b0, 32'sd9}) begin
            n_fail++;
            $display("[TB] FAIL signed_7_m2: got q=%0h r=%0h err=%b lat=%0d, expected fd 1 0 9", q, r, e, lat);
        end
        run_op(8, 1'b1, 64'h80, 64'hFF, 1'b0, q, r, e, lat, low);
        n_cmp++;
        if ({q, r, e, lat} !== {64'h80, 64'h00, 1'b0, 32'sd9}) begin
            n_fail++;
            $display("[TB] FAIL signed_min_m1: got q=%0h r=%0h err=%b lat=%0d, expected 80 0 0 9", q, r, e, lat);
        end
`else
        run_op(8, 1'b1, 64'hF9, 64'd2, 1'b0, q, r, e, lat, low);
        n_cmp++;
        if ({q, r, e, lat} !== {64'd124, 64'd1, 1'b0, 32'sd9}) begin
            n_fail++;
            $display("[TB] FAIL unsigned_249_2: got q=%0d r=%0d err=%b lat=%0d, expected 124 1 0 9", q, r, e, lat);
        end
`endif
        n_cmp++;
        if (low !== 10) begin
            n_fail++;
            $display("[TB] FAIL signed_ready_low: got %0d, expected 10", low);
        end
    endtask

    task automatic test_random(input int w, input int n_ops);
        logic [63:0] mask, a, b, q, r, eq, er;
        logic        e, ee, s;
        int          lat, low, a0, v0, elat;
        mask = (64'd1 << w) - 64'd1;
        a0 = (w == 8) ? acc8 : acc13;
        v0 = (w == 8) ? val8 : val13;
        for (int i = 0; i < n_ops; i++) begin
            a = {$urandom, $urandom} & mask;
            b = {$urandom, $urandom} & mask;
            case ($urandom_range(0, 15))
                0: b = 64'd0;
                1: a = mask;
                2: a = 64'd1 << (w - 1);
                3: b = mask;
                4: b = 64'd1;
                5: begin a = 64'd1 << (w - 1); b = mask; end
                default: ;
            endcase
            s = 1'($urandom_range(0, 1));
            ref_div(w, s, a, b, eq, er, ee);
            run_op(w, s, a, b, 1'b1, q, r, e, lat, low);
            elat = (b == 64'd0) ? 0 : w + 1;
            n_cmp++;
            if ({q, r, e} !== {eq, er, ee}) begin
                n_fail++;
                $display("[TB] FAIL rand_w%0d_result: %0h/%0h sgn=%b got q=%0h r=%0h err=%b, expected q=%0h r=%0h err=%b",
                         w, a, b, s, q, r, e, eq, er, ee);
            end
            n_cmp++;
            if (lat !== elat || low !== elat + 1) begin
                n_fail++;
                $display("[TB] FAIL rand_w%0d_timing: %0h/%0h got latency=%0d ready_low=%0d, expected %0d and %0d",
                         w, a, b, lat, low, elat, elat + 1);
            end
        end
        n_cmp++;
        if ((((w == 8) ? acc8 : acc13) - a0) !== n_ops) begin
            n_fail++;
            $display("[TB] FAIL rand_w%0d_accepted: got %0d, expected %0d", w, ((w == 8) ? acc8 : acc13) - a0, n_ops);
        end
        n_cmp++;
        if ((((w == 8) ? val8 : val13) - v0) !== n_ops) begin
            n_fail++;
            $display("[TB] FAIL rand_w%0d_valids: got %0d, expected %0d", w, ((w == 8) ? val8 : val13) - v0, n_ops);
        end
    endtask

    initial begin
        $display("[TB] int_divider_seq bench, signed feature %0d", SIGNED_EN);
        test_reset();
        test_basic();
        test_div_zero();
        test_back_to_back();
        test_reset_mid();
        test_signed();
        test_random(8, 2000);
        test_random(13, 2000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
